// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [15:0] STALL_CNT_MAX    = 16'hFFFF;

    localparam int unsigned RS_MSB  = 25;
    localparam int unsigned RS_LSB  = 21;
    localparam int unsigned RT_MSB  = 20;
    localparam int unsigned RT_LSB  = 16;
    localparam int unsigned RD_MSB  = 15;
    localparam int unsigned RD_LSB  = 11;
    localparam int unsigned IMM_MSB = 15;
    localparam int unsigned IMM_LSB = 0;

    typedef enum logic [1:0] {
        LATCH_LOAD   = 2'd0,
        LATCH_HOLD   = 2'd1,
        LATCH_BUBBLE = 2'd2
    } latch_ctrl_e;

endpackage

// File: rtl/fetch_stage_if_rf_latch.sv
// IF/RF pipeline register set: load a fetched word, hold it, or replace it with a bubble.
module if_rf_latch
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  ctrl,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] pc_plus4_in,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        valid
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic        valid_q, valid_d;

    always_comb begin
        instr_d    = instr_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        case (latch_ctrl_e'(ctrl))
            LATCH_LOAD: begin
                instr_d    = instr_in;
                pc_d       = pc_in;
                pc_plus4_d = pc_plus4_in;
                valid_d    = 1'b1;
            end
            LATCH_BUBBLE: begin
                instr_d    = NOP_WORD;
                pc_d       = 32'd0;
                pc_plus4_d = 32'd0;
                valid_d    = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q    <= NOP_WORD;
            pc_q       <= 32'd0;
            pc_plus4_q <= 32'd0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign instr    = instr_q;
    assign pc       = pc_q;
    assign pc_plus4 = pc_plus4_q;
    assign valid    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC sequencing with redirect/stall, IF/RF register, misalign flag and stall counter.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic        if_valid,
    output logic [4:0]  if_rs,
    output logic [4:0]  if_rt,
    output logic [4:0]  if_rd,
    output logic [15:0] if_imm,
    output logic        misalign_err,
    output logic [15:0] stall_count
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4;
    logic        misalign_q, misalign_d;
    logic [15:0] stall_count_q, stall_count_d;
    latch_ctrl_e latch_ctrl;

    assign pc_plus4 = pc_q + PC_INC;

    always_comb begin
        pc_d          = pc_plus4;
        latch_ctrl    = LATCH_LOAD;
        misalign_d    = misalign_q;
        stall_count_d = stall_count_q;

        // Redirect wins over stall; the target is forced to word alignment.
        if (redirect_valid) begin
            pc_d = {redirect_target[31:2], 2'b00};
        end else if (stall) begin
            pc_d = pc_q;
        end

        if (flush || redirect_valid) begin
            latch_ctrl = LATCH_BUBBLE;
        end else if (stall) begin
            latch_ctrl = LATCH_HOLD;
        end

        if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
            misalign_d = 1'b1;
        end

        if (stall && (stall_count_q != STALL_CNT_MAX)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            misalign_q    <= 1'b0;
            stall_count_q <= 16'd0;
        end else begin
            pc_q          <= pc_d;
            misalign_q    <= misalign_d;
            stall_count_q <= stall_count_d;
        end
    end

    if_rf_latch #(
        .NOP_WORD (NOP_WORD)
    ) u_if_rf_latch (
        .clk         (clk),
        .reset       (reset),
        .ctrl        (latch_ctrl),
        .instr_in    (imem_data),
        .pc_in       (pc_q),
        .pc_plus4_in (pc_plus4),
        .instr       (if_instr),
        .pc          (if_pc),
        .pc_plus4    (if_pc_plus4),
        .valid       (if_valid)
    );

    assign imem_addr    = pc_q;
    assign if_rs        = if_instr[RS_MSB:RS_LSB];
    assign if_rt        = if_instr[RT_MSB:RT_LSB];
    assign if_rd        = if_instr[RD_MSB:RD_LSB];
    assign if_imm       = if_instr[IMM_MSB:IMM_LSB];
    assign misalign_err = misalign_q;
    assign stall_count  = stall_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: two instances (default and wrapping reset PC) against a behavioural model.
module tb_fetch_stage;

    localparam logic [31:0] A_RESET = 32'h0000_0000;
    localparam logic [31:0] B_RESET = 32'hFFFF_FFFC;
    localparam logic [31:0] NOP     = 32'h0000_0000;

    logic        clk, reset, stall, flush, redirect_valid;
    logic [31:0] redirect_target;

    logic [31:0] a_addr, a_data, a_instr, a_pc, a_pc4;
    logic        a_valid, a_mis;
    logic [4:0]  a_rs, a_rt, a_rd;
    logic [15:0] a_imm, a_sc;

    logic [31:0] b_addr, b_data, b_instr, b_pc, b_pc4;
    logic        b_valid, b_mis;
    logic [4:0]  b_rs, b_rt, b_rd;
    logic [15:0] b_imm, b_sc;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] ipc;
        logic [31:0] ipc4;
        logic        valid;
        logic        mis;
        logic [15:0] sc;
    } model_t;

    model_t ma, mb;

    function automatic logic [31:0] imem_f(input logic [31:0] a);
        if (a == 32'd0) return 32'h2008_0005;
        return {a[15:0] ^ 16'h5A5A, a[31:16]} + 32'h1234_5678;
    endfunction

    assign a_data = imem_f(a_addr);
    assign b_data = imem_f(b_addr);

    fetch_stage #(.RESET_PC(A_RESET), .NOP_WORD(NOP)) u_a (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .imem_addr(a_addr), .imem_data(a_data),
        .if_instr(a_instr), .if_pc(a_pc), .if_pc_plus4(a_pc4), .if_valid(a_valid),
        .if_rs(a_rs), .if_rt(a_rt), .if_rd(a_rd), .if_imm(a_imm),
        .misalign_err(a_mis), .stall_count(a_sc)
    );

    fetch_stage #(.RESET_PC(B_RESET), .NOP_WORD(NOP)) u_b (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .imem_addr(b_addr), .imem_data(b_data),
        .if_instr(b_instr), .if_pc(b_pc), .if_pc_plus4(b_pc4), .if_valid(b_valid),
        .if_rs(b_rs), .if_rt(b_rt), .if_rd(b_rd), .if_imm(b_imm),
        .misalign_err(b_mis), .stall_count(b_sc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic model_t mreset(input logic [31:0] rpc);
        model_t n;
        n.pc = rpc; n.instr = NOP; n.ipc = 32'd0; n.ipc4 = 32'd0;
        n.valid = 1'b0; n.mis = 1'b0; n.sc = 16'd0;
        return n;
    endfunction

    // One clock edge of the fetch stage as described by its rules.
    function automatic model_t step(input model_t m, input logic st, input logic fl,
                                    input logic rv, input logic [31:0] tgt);
        model_t n;
        n = m;
        if (rv)       n.pc = tgt & 32'hFFFF_FFFC;
        else if (!st) n.pc = m.pc + 32'd4;
        if (fl || rv) begin
            n.instr = NOP; n.ipc = 32'd0; n.ipc4 = 32'd0; n.valid = 1'b0;
        end else if (!st) begin
            n.instr = imem_f(m.pc); n.ipc = m.pc; n.ipc4 = m.pc + 32'd4; n.valid = 1'b1;
        end
        if (rv && tgt[1:0] != 2'b00) n.mis = 1'b1;
        if (st && m.sc != 16'hFFFF) n.sc = m.sc + 16'd1;
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ma = mreset(A_RESET);
            mb = mreset(B_RESET);
        end else begin
            ma = step(ma, stall, flush, redirect_valid, redirect_target);
            mb = step(mb, stall, flush, redirect_valid, redirect_target);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic cmp_all(input string tag, input model_t m,
                           input logic [31:0] addr, input logic [31:0] instr,
                           input logic [31:0] ipc, input logic [31:0] ipc4,
                           input logic valid, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [15:0] imm,
                           input logic mis, input logic [15:0] sc);
        chk({tag, ".imem_addr"},   addr,  m.pc);
        chk({tag, ".if_instr"},    instr, m.instr);
        chk({tag, ".if_pc"},       ipc,   m.ipc);
        chk({tag, ".if_pc_plus4"}, ipc4,  m.ipc4);
        chk({tag, ".if_valid"},    {31'd0, valid}, {31'd0, m.valid});
        chk({tag, ".if_rs"},       {27'd0, rs},  {27'd0, m.instr[25:21]});
        chk({tag, ".if_rt"},       {27'd0, rt},  {27'd0, m.instr[20:16]});
        chk({tag, ".if_rd"},       {27'd0, rd},  {27'd0, m.instr[15:11]});
        chk({tag, ".if_imm"},      {16'd0, imm}, {16'd0, m.instr[15:0]});
        chk({tag, ".misalign_err"}, {31'd0, mis}, {31'd0, m.mis});
        chk({tag, ".stall_count"}, {16'd0, sc},  {16'd0, m.sc});
    endtask

    always @(negedge clk) begin
        cmp_all("a", ma, a_addr, a_instr, a_pc, a_pc4, a_valid, a_rs, a_rt, a_rd, a_imm, a_mis, a_sc);
        cmp_all("b", mb, b_addr, b_instr, b_pc, b_pc4, b_valid, b_rs, b_rt, b_rd, b_imm, b_mis, b_sc);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] tgt;
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        redirect_valid = 1'b0; redirect_target = 32'd0;
        repeat (2) tick();
        chk("lit.rst.a_addr",  a_addr, 32'h0);
        chk("lit.rst.a_valid", {31'd0, a_valid}, 32'd0);
        chk("lit.rst.b_addr",  b_addr, 32'hFFFF_FFFC);
        reset = 1'b0;

        tick();
        chk("lit.first.a_instr", a_instr, 32'h2008_0005);
        chk("lit.first.a_pc",    a_pc, 32'h0);
        chk("lit.first.a_pc4",   a_pc4, 32'h4);
        chk("lit.first.a_valid", {31'd0, a_valid}, 32'd1);
        chk("lit.first.a_addr",  a_addr, 32'h4);
        chk("lit.wrap.b_addr",   b_addr, 32'h0);
        chk("lit.wrap.b_pc",     b_pc, 32'hFFFF_FFFC);
        chk("lit.wrap.b_pc4",    b_pc4, 32'h0);
        tick();
        chk("lit.wrap2.b_addr",  b_addr, 32'h4);
        chk("lit.seq.a_addr",    a_addr, 32'h8);

        stall = 1'b1;
        repeat (3) begin
            tick();
            chk("lit.stall.a_addr", a_addr, 32'h8);
            chk("lit.stall.a_pc",   a_pc, 32'h4);
        end
        chk("lit.stall.a_sc", {16'd0, a_sc}, 32'd3);
        stall = 1'b0;
        tick();
        chk("lit.resume.a_addr", a_addr, 32'hC);

        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0000_0040;
        tick();
        chk("lit.redir.a_addr",  a_addr, 32'h40);
        chk("lit.redir.a_valid", {31'd0, a_valid}, 32'd0);
        chk("lit.redir.a_instr", a_instr, NOP);
        chk("lit.redir.a_mis",   {31'd0, a_mis}, 32'd0);

        stall = 1'b0; redirect_target = 32'h0000_0046;
        tick();
        chk("lit.misal.a_addr", a_addr, 32'h44);
        chk("lit.misal.a_mis",  {31'd0, a_mis}, 32'd1);
        redirect_valid = 1'b0;
        repeat (3) tick();
        chk("lit.sticky.a_mis", {31'd0, a_mis}, 32'd1);

        stall = 1'b1;
        tick();
        #2 reset = 1'b1;
        #1;
        chk("lit.async.a_addr",  a_addr, 32'h0);
        chk("lit.async.a_valid", {31'd0, a_valid}, 32'd0);
        chk("lit.async.a_instr", a_instr, NOP);
        chk("lit.async.a_pc",    a_pc, 32'h0);
        chk("lit.async.a_sc",    {16'd0, a_sc}, 32'd0);
        chk("lit.async.a_mis",   {31'd0, a_mis}, 32'd0);
        tick();
        reset = 1'b0; stall = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 6) == 0);
            redirect_valid = ($urandom_range(0, 6) == 0);
            tgt = $urandom;
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            if ($urandom_range(0, 9) == 0) tgt = 32'hFFFF_FFF0 | {28'd0, tgt[3:0]};
            redirect_target = tgt;
            if ($urandom_range(0, 99) == 0) begin
                #2 reset = 1'b1;
                tick();
                reset = 1'b0;
            end else begin
                tick();
            end
        end

        stall = 1'b1; flush = 1'b0; redirect_valid = 1'b0;
        #2 reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (65540) tick();
        chk("lit.sat.a_sc",   {16'd0, a_sc}, 32'h0000_FFFF);
        chk("lit.sat.a_addr", a_addr, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, byte address loaded into PC on reset.
REQ-002 Parameter NOP_WORD, default 32'h0000_0000, instruction word presented in a bubble.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 stall  input  1  hazard hold; freezes PC and IF/RF outputs.
REQ-006 flush  input  1  squash the instruction entering IF/RF.
REQ-007 redirect_valid  input  1  taken branch/jump/jr this cycle.
REQ-008 redirect_target  input  32  byte address of the next fetch when redirect_valid=1.
REQ-009 imem_addr  output  32  byte address to instruction memory, equal to current PC.
REQ-010 imem_data  input  32  combinational instruction word for imem_addr.
REQ-011 if_instr  output  32  registered instruction for the RF stage.
REQ-012 if_pc  output  32  registered address of if_instr.
REQ-013 if_pc_plus4  output  32  if_pc + 4, registered, for JAL link.
REQ-014 if_valid  output  1  1 = if_instr is a real instruction, 0 = bubble.
REQ-015 if_rs, if_rt, if_rd  output  5 each  fields [25:21], [20:16], [15:11] of if_instr.
REQ-016 if_imm  output  16  field [15:0] of if_instr.
REQ-017 misalign_err  output  1  sticky flag, set when redirect_target[1:0] != 0.
REQ-018 stall_count  output  16  saturating count of stalled cycles since reset.

Function
REQ-019 imem_addr SHALL equal the PC register combinationally; no extra latency.
REQ-020 Next-PC priority SHALL be: reset > redirect_valid > stall > sequential.
REQ-021 redirect_valid=1: PC <= {redirect_target[31:2],2'b00}; redirect overrides stall.
REQ-022 stall=1, redirect_valid=0: PC, if_instr, if_pc, if_pc_plus4, if_valid SHALL hold.
REQ-023 Sequential case: PC <= PC + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-024 IF/RF update priority SHALL be: reset > (flush | redirect_valid) > stall > load.
REQ-025 flush or redirect_valid: if_instr <= NOP_WORD, if_valid <= 0, if_pc/if_pc_plus4 <= 0.
REQ-026 Load case: if_instr <= imem_data, if_pc <= PC, if_pc_plus4 <= PC+4, if_valid <= 1.
REQ-027 flush without redirect SHALL NOT alter PC sequencing (PC advances unless stall).
REQ-028 flush and stall together: bubble inserted, PC held.
REQ-029 Fetch-to-RF latency SHALL be exactly one cycle absent stall/flush.
REQ-030 if_rs/if_rt/if_rd/if_imm SHALL be combinational slices of the registered if_instr.
REQ-031 misalign_err SHALL set on the edge where redirect_valid=1 with target[1:0]!=0 and clear only on reset.
REQ-032 stall_count SHALL increment on each edge with stall=1, saturating at 16'hFFFF.

Reset
REQ-033 Asserting reset SHALL immediately force PC=RESET_PC, if_instr=NOP_WORD, if_pc=0, if_pc_plus4=0, if_valid=0, misalign_err=0, stall_count=0.
REQ-034 First edge after reset release SHALL load instruction at RESET_PC into IF/RF with if_valid=1 (unless stall/flush/redirect).
REQ-035 Reset asserted mid-stall or mid-redirect SHALL discard pending state; no redirect survives reset.

Structure
REQ-036 Shared package SHALL hold RESET_PC default, NOP_WORD, instruction field bit positions, PC increment constant 4.
REQ-037 One sub-module if_rf_latch SHALL hold the IF/RF register set (instr, pc, pc_plus4, valid) with load/hold/bubble controls; PC logic stays in fetch_stage.

Verification
REQ-038 Reset, imem returns 32'h2008_0005 at 0 -> after first edge if_instr=32'h2008_0005, if_pc=0, if_pc_plus4=4, if_valid=1, imem_addr=4.
REQ-039 Stall held 3 cycles at PC=8 -> PC stays 8, IF/RF outputs unchanged, stall_count=3, then resumes with PC=12.
REQ-040 redirect_valid=1, target=32'h0000_0040, stall=1 same cycle -> PC=0x40, if_valid=0, if_instr=NOP_WORD next cycle.
REQ-041 redirect target 32'h0000_0046 -> PC=0x44, misalign_err=1 and stays 1 until reset.
REQ-042 RESET_PC=32'hFFFF_FFFC, run 2 cycles -> PC sequence FFFF_FFFC, 0, 4; if_pc_plus4 of first instr=0.
REQ-043 Assert reset asynchronously between edges during stall -> all outputs at reset values before next edge.
